// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker: FSM state encoding,
// fail codes and a width helper for the expected-entry table index.
package memchk_pkg;

    typedef enum logic [1:0] {LOAD, RUN, PASS, FAIL} chkState;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;

    // A one-entry table still needs a 1-bit index.
    function automatic int idxWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_write_checker_if.sv
// Table-load, observed-store and status signals of the write checker.
// err_addr/err_data exist only when MEMCHK_ERR_CAPTURE_EN is defined.
interface mem_write_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
);
    localparam int MC_W = $clog2(DEPTH + 1);

    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              start;
    logic              MemWriteM;
    logic [ADDR_W-1:0] DataAdrM;
    logic [DATA_W-1:0] WriteDataM;
    logic              done;
    logic              pass;
    logic              fail;
    logic [1:0]        fail_code;
    logic [MC_W-1:0]   match_count;
    logic [CNT_W-1:0]  cycle_count;
`ifdef MEMCHK_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;
`endif

    modport master (
        output exp_we, exp_addr, exp_data, start, MemWriteM, DataAdrM, WriteDataM,
        input  done, pass, fail, fail_code, match_count,
`ifdef MEMCHK_ERR_CAPTURE_EN
        input  err_addr, err_data,
`endif
        input  cycle_count
    );

    modport slave (
        input  exp_we, exp_addr, exp_data, start, MemWriteM, DataAdrM, WriteDataM,
        output done, pass, fail, fail_code, match_count,
`ifdef MEMCHK_ERR_CAPTURE_EN
        output err_addr, err_data,
`endif
        output cycle_count
    );

endinterface

// File: rtl/mem_write_checker_table.sv
// Expected-store register file: one synchronous write port, one combinational
// read port. No reset; the checker tracks valid entries with its load pointer.
module memchk_table #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [IDX_W-1:0]         wrIdx,
    input  logic [ADDR_W+DATA_W-1:0] wrEntry,
    input  logic [IDX_W-1:0]         rdIdx,
    output logic [ADDR_W+DATA_W-1:0] rdEntry
);
    logic [DEPTH-1:0][ADDR_W+DATA_W-1:0] mem;

    always_ff @(posedge clk) begin
        if (we) mem[wrIdx] <= wrEntry;
    end

    assign rdEntry = mem[rdIdx];

endmodule

// File: rtl/mem_write_checker.sv
// In-order store checker: compares each observed store against a preloaded
// table, reports sticky pass/fail/timeout. MEMCHK_ERR_CAPTURE_EN adds err_addr/err_data.
module mem_write_checker
    import memchk_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_write_checker_if.slave bus
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int IW = idxWidth(DEPTH);
    localparam int EW = ADDR_W + DATA_W;
    localparam logic [PW-1:0]    DEPTH_P = PW'(DEPTH);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    chkState          state, stateNext;
    logic [PW-1:0]    loadPtr, loadPtrNext, chkPtr, chkPtrNext, chkInc;
    logic [CNT_W-1:0] cycleCnt, cycleCntNext;
    logic [1:0]       failCode, failCodeNext;
    logic             passQ, failQ, doneQ;
    logic             tblWe, hit, errCapture;
    logic [IW-1:0]    rdIdx;
    logic [EW-1:0]    tblRd;

    assign tblWe  = !reset && (state == LOAD) && bus.exp_we && (loadPtr != DEPTH_P);
    assign rdIdx  = (chkPtr < DEPTH_P) ? chkPtr[IW-1:0] : '0;
    assign hit    = (tblRd == {bus.DataAdrM, bus.WriteDataM});
    assign chkInc = chkPtr + 1'b1;

    memchk_table #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IW)) uTable (
        .clk     (clk),
        .we      (tblWe),
        .wrIdx   (loadPtr[IW-1:0]),
        .wrEntry ({bus.exp_addr, bus.exp_data}),
        .rdIdx   (rdIdx),
        .rdEntry (tblRd)
    );

    always_comb begin
        stateNext    = state;
        loadPtrNext  = loadPtr;
        chkPtrNext   = chkPtr;
        cycleCntNext = cycleCnt;
        failCodeNext = failCode;
        errCapture   = 1'b0;
        case (state)
            LOAD: begin
                if (tblWe) loadPtrNext = loadPtr + 1'b1;
                // A same-cycle load counts toward the table size seen by start.
                if (bus.start) stateNext = (loadPtrNext != '0) ? RUN : PASS;
            end
            RUN: begin
                if (cycleCnt != '1) cycleCntNext = cycleCnt + 1'b1;
                // Mismatch outranks timeout; a final match outranks timeout.
                if (bus.MemWriteM && !hit) begin
                    stateNext    = FAIL;
                    failCodeNext = FC_MISMATCH;
                    errCapture   = 1'b1;
                end else if (bus.MemWriteM && (chkInc == loadPtr)) begin
                    chkPtrNext = chkInc;
                    stateNext  = PASS;
                end else begin
                    if (bus.MemWriteM) chkPtrNext = chkInc;
                    if (cycleCnt == TO_LAST) begin
                        stateNext    = FAIL;
                        failCodeNext = FC_TIMEOUT;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= LOAD;
            loadPtr  <= '0;
            chkPtr   <= '0;
            cycleCnt <= '0;
            failCode <= FC_NONE;
            passQ    <= 1'b0;
            failQ    <= 1'b0;
            doneQ    <= 1'b0;
        end else begin
            state    <= stateNext;
            loadPtr  <= loadPtrNext;
            chkPtr   <= chkPtrNext;
            cycleCnt <= cycleCntNext;
            failCode <= failCodeNext;
            passQ    <= (stateNext == PASS);
            failQ    <= (stateNext == FAIL);
            doneQ    <= (stateNext == PASS) || (stateNext == FAIL);
        end
    end

`ifdef MEMCHK_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] errAddr;
    logic [DATA_W-1:0] errData;

    always_ff @(posedge clk) begin
        if (reset) begin
            errAddr <= '0;
            errData <= '0;
        end else if (errCapture) begin
            errAddr <= bus.DataAdrM;
            errData <= bus.WriteDataM;
        end
    end

    assign bus.err_addr = errAddr;
    assign bus.err_data = errData;
`endif

    assign bus.done        = doneQ;
    assign bus.pass        = passQ;
    assign bus.fail        = failQ;
    assign bus.fail_code   = failCode;
    assign bus.match_count = chkPtr;
    assign bus.cycle_count = cycleCnt;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: expected status pushed to a queue as each
// step is driven, popped and compared one cycle later.
module tb_mem_write_checker;
    import memchk_pkg::*;

    localparam int ADDR_W = 32, DATA_W = 32, DEPTH = 8, TIMEOUT_CYC = 20, CNT_W = 32;

    typedef struct {
        logic       done, pass, fail;
        logic [1:0] code;
        int         mc, cc;
    } expT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    expT  expQ[$];

    always #5 clk = ~clk;

    mem_write_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    mem_write_checker #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
        .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic expT mk(input logic d, p, f, input logic [1:0] c, input int mc, cc);
        expT e;
        e.done = d; e.pass = p; e.fail = f; e.code = c; e.mc = mc; e.cc = cc;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic popCheck(input string tag);
        expT e;
        e = expQ.pop_front();
        chk({tag, ".done"}, 64'(bus.done), 64'(e.done));
        chk({tag, ".pass"}, 64'(bus.pass), 64'(e.pass));
        chk({tag, ".fail"}, 64'(bus.fail), 64'(e.fail));
        chk({tag, ".code"}, 64'(bus.fail_code), 64'(e.code));
        chk({tag, ".mc"},   64'(bus.match_count), 64'(e.mc));
        chk({tag, ".cc"},   64'(bus.cycle_count), 64'(e.cc));
    endtask

    task automatic stepExp(input string tag, input expT e);
        expQ.push_back(e);
        step();
        popCheck(tag);
    endtask

    task automatic doReset();
        reset = 1'b1;
        bus.exp_we = 1'b0; bus.start = 1'b0; bus.MemWriteM = 1'b0;
        bus.exp_addr = '0; bus.exp_data = '0; bus.DataAdrM = '0; bus.WriteDataM = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.exp_we = 1'b1; bus.exp_addr = a; bus.exp_data = d;
        step();
        bus.exp_we = 1'b0;
    endtask

    task automatic startRun();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic storeExp(input string tag, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input expT e);
        bus.MemWriteM = 1'b1; bus.DataAdrM = a; bus.WriteDataM = d;
        stepExp(tag, e);
        bus.MemWriteM = 1'b0;
    endtask

    initial begin
        // Reset state, with stray load/start activity that reset must override
        bus.exp_we = 1'b1; bus.start = 1'b1; bus.MemWriteM = 1'b1;
        bus.exp_addr = 32'h64; bus.exp_data = 32'h7; bus.DataAdrM = '0; bus.WriteDataM = '0;
        expQ.push_back(mk(0, 0, 0, FC_NONE, 0, 0));
        step();
        popCheck("reset");
        chk("reset.state", 64'(dut.state), 64'(LOAD));

        // In-order pass
        doReset();
        load(32'h64, 32'h7);
        load(32'h64, 32'h7);
        startRun();
        storeExp("pass.st1", 32'h64, 32'h7, mk(0, 0, 0, FC_NONE, 1, 1));
        storeExp("pass.st2", 32'h64, 32'h7, mk(1, 1, 0, FC_NONE, 2, 2));
        stepExp("pass.hold", mk(1, 1, 0, FC_NONE, 2, 2));

        // Mismatch, then later matching stores are ignored
        doReset();
        load(32'h64, 32'h7);
        startRun();
        storeExp("mis.st", 32'h64, 32'h8, mk(1, 0, 1, FC_MISMATCH, 0, 1));
`ifdef MEMCHK_ERR_CAPTURE_EN
        chk("mis.err_addr", 64'(bus.err_addr), 64'h64);
        chk("mis.err_data", 64'(bus.err_data), 64'h8);
`endif
        storeExp("mis.after", 32'h64, 32'h7, mk(1, 0, 1, FC_MISMATCH, 0, 1));

        // Timeout with undriven buses while MemWriteM is low
        doReset();
        load(32'h40, 32'h5);
        startRun();
        bus.DataAdrM = 'x; bus.WriteDataM = 'x;
        repeat (18) step();
        stepExp("to.pre", mk(0, 0, 0, FC_NONE, 0, 19));
        stepExp("to.hit", mk(1, 0, 1, FC_TIMEOUT, 0, 20));
`ifdef MEMCHK_ERR_CAPTURE_EN
        chk("to.err_addr", 64'(bus.err_addr), 64'h0);
`endif
        storeExp("to.late", 32'h40, 32'h5, mk(1, 0, 1, FC_TIMEOUT, 0, 20));

        // Final match on the timeout cycle passes
        doReset();
        load(32'h40, 32'h5);
        startRun();
        repeat (19) step();
        storeExp("tomatch", 32'h40, 32'h5, mk(1, 1, 0, FC_NONE, 1, 20));

        // Mismatch on the timeout cycle reports mismatch
        doReset();
        load(32'h40, 32'h5);
        startRun();
        repeat (19) step();
        storeExp("tomis", 32'h40, 32'h6, mk(1, 0, 1, FC_MISMATCH, 0, 20));

        // Nine loads into eight entries: the ninth is dropped
        doReset();
        for (int i = 0; i < 9; i++) load(32'h100 + 32'(i * 4), 32'(i * 3 + 1));
        startRun();
        for (int i = 0; i < 7; i++)
            storeExp("full.st", 32'h100 + 32'(i * 4), 32'(i * 3 + 1), mk(0, 0, 0, FC_NONE, i + 1, i + 1));
        storeExp("full.last", 32'h11c, 32'd22, mk(1, 1, 0, FC_NONE, 8, 8));
        storeExp("full.ninth", 32'h120, 32'd25, mk(1, 1, 0, FC_NONE, 8, 8));

        // Empty table passes on start
        doReset();
        bus.start = 1'b1;
        stepExp("empty", mk(1, 1, 0, FC_NONE, 0, 0));
        bus.start = 1'b0;

        // Load and start together: that entry is part of the check
        doReset();
        load(32'h10, 32'h1);
        bus.exp_we = 1'b1; bus.exp_addr = 32'h20; bus.exp_data = 32'h2; bus.start = 1'b1;
        step();
        bus.exp_we = 1'b0; bus.start = 1'b0;
        storeExp("wes.st1", 32'h10, 32'h1, mk(0, 0, 0, FC_NONE, 1, 1));
        storeExp("wes.st2", 32'h20, 32'h2, mk(1, 1, 0, FC_NONE, 2, 2));

        // Reset mid-run after three matches
        doReset();
        for (int i = 0; i < 4; i++) load(32'h200 + 32'(i), 32'(i + 10));
        startRun();
        for (int i = 0; i < 3; i++)
            storeExp("rr.st", 32'h200 + 32'(i), 32'(i + 10), mk(0, 0, 0, FC_NONE, i + 1, i + 1));
        reset = 1'b1;
        stepExp("rr.reset", mk(0, 0, 0, FC_NONE, 0, 0));
        reset = 1'b0;
        chk("rr.state", 64'(dut.state), 64'(LOAD));
        storeExp("rr.ignored", 32'h200, 32'd10, mk(0, 0, 0, FC_NONE, 0, 0));
        bus.start = 1'b1;
        stepExp("rr.emptystart", mk(1, 1, 0, FC_NONE, 0, 0));
        bus.start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_write_checker.md
Name: mem_write_checker

Overview:
- Synthesizable self-check monitor for the pipelined processor top level. It watches the data-memory write bus and compares each store, in order, against a preloaded table of expected (address, data) pairs.
- It reports pass, fail, or timeout with sticky status, a match count, and a cycle count.
- It replaces a hard-wired single-address success check. Width, table depth and timeout are parametrised.
- It sits beside the processor top in benches and FPGA bring-up wrappers, tapping the same write-data, address and write-enable signals the top exports.

Parameters:
- ADDR_W, 32, width of the monitored address bus
- DATA_W, 32, width of the monitored write-data bus
- DEPTH, 8, number of expected-write table entries (≥1)
- TIMEOUT_CYC, 1000, RUN-state cycle budget before a timeout fail (≥1)
- CNT_W, 32, width of cycle_count

Ports:
- clk  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- exp_we  in  1  load strobe; writes one expected entry
- exp_addr  in  ADDR_W  expected store address
- exp_data  in  DATA_W  expected store data
- start  in  1  single-cycle pulse; ends loading and begins checking
- MemWriteM  in  1  observed store enable
- DataAdrM  in  ADDR_W  observed store address
- WriteDataM  in  DATA_W  observed store data
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail  out  1  high in FAIL
- fail_code  out  2  0 none, 1 mismatch, 2 timeout, 3 reserved
- match_count  out  $clog2(DEPTH+1)  number of expected entries matched so far
- cycle_count  out  CNT_W  cycles spent in RUN; saturates at its maximum

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous, active-high, named reset.
- Reset state: state=LOAD; load_ptr, chk_ptr, match_count and cycle_count are 0; done, pass and fail are 0; fail_code=0. Reset wins over every other input in the same cycle. Reset mid-RUN aborts the check and clears the table count, so the table must be reloaded.
- States: LOAD, RUN, PASS, FAIL. PASS and FAIL are sticky until reset.
- LOAD:
  - exp_we=1 writes table[load_ptr] and increments load_ptr.
  - When load_ptr==DEPTH, further exp_we is ignored (no wrap).
  - MemWriteM is ignored in LOAD.
- start in LOAD:
  - If exp_we and start are high in the same cycle, the entry is stored first and the number of loaded entries includes it.
  - Next state is RUN if the number of loaded entries is >0; otherwise PASS (empty table passes trivially).
  - start outside LOAD is ignored.
- RUN, every cycle:
  - cycle_count increments, saturating.
  - If MemWriteM=1, compare {DataAdrM, WriteDataM} against table[chk_ptr]:
    - Match: chk_ptr and match_count increment. If this was the last loaded entry, next state is PASS.
    - Mismatch: next state is FAIL with fail_code=1; match_count is frozen.
  - If cycle_count==TIMEOUT_CYC-1 and the check is not completing this cycle, next state is FAIL with fail_code=2.
  - A final match and the timeout in the same cycle give PASS; a mismatch and the timeout in the same cycle give fail_code=1.
  - MemWriteM=0 cycles are never compared; X or Z on the buses while MemWriteM=0 has no effect.
  - exp_we is ignored in RUN.
- Outputs: all outputs are registered. Status becomes visible one cycle after the deciding store (latency 1). In PASS and FAIL, cycle_count and match_count hold.

Optional Feature:
- Macro MEMCHK_ERR_CAPTURE_EN.
- Defined: adds output ports err_addr (ADDR_W) and err_data (DATA_W). On a mismatch they capture the offending DataAdrM and WriteDataM; they are 0 at reset and on timeout, and hold in FAIL.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Package memchk_pkg holds the state encoding (LOAD, RUN, PASS, FAIL) and the fail_code constants FC_NONE, FC_MISMATCH, FC_TIMEOUT.
- Sub-module memchk_table: DEPTH×(ADDR_W+DATA_W) register file with one synchronous write port and one combinational read port indexed by chk_ptr. It has no reset; validity is tracked by load_ptr.
- The FSM and counters stay in mem_write_checker.

Test Plan:
- In-order pass: load (0x64,7) and (0x64,7) with DEPTH=8, start, drive two stores matching them → pass=1 and done=1 one cycle after the second store; match_count=2; fail_code=0.
- Mismatch: load (0x64,7), start, store (0x64,8) → fail=1, fail_code=1, match_count=0; with MEMCHK_ERR_CAPTURE_EN, err_addr=0x64 and err_data=8. Later matching stores leave the status unchanged.
- Timeout: TIMEOUT_CYC=20, load 1 entry, start, no stores → fail_code=2 with cycle_count=20 visible on the cycle fail rises; a store in cycle 21 is ignored.
- Boundary: load 9 entries with DEPTH=8 → the 9th is dropped and 8 matches give pass. Also: start with an empty table → pass the next cycle. Also: exp_we and start in the same cycle → that entry is checked.
- Simultaneous events: final match on the timeout cycle → pass. Also: assert reset during RUN after 3 matches → all outputs return to 0 and state=LOAD; a store afterwards is ignored until start.
